// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar datapath: default widths, accumulator FSM states and
// the saturation limit helper.
package crossbar_pkg;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 12;

  typedef enum logic {ACCUM, HOLD} acc_state_t;

  // Largest unsigned value representable in width bits (width < 32).
  function automatic int unsigned sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/crossbar_accumulator_if.sv
// Product input and dot-product result handshakes of the crossbar accumulator.
interface crossbar_accumulator_if #(
  parameter int unsigned PROD_W = crossbar_pkg::PROD_W,
  parameter int unsigned ACC_W  = crossbar_pkg::ACC_W
);
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod_data;
  logic              sum_valid;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum_data;
  logic              sum_ovf;

  // master: the upstream crossbar plus the downstream consumer; slave: the accumulator.
  modport master (
    output prod_valid, prod_data, sum_ready,
    input  prod_ready, sum_valid, sum_data, sum_ovf
  );

  modport slave (
    input  prod_valid, prod_data, sum_ready,
    output prod_ready, sum_valid, sum_data, sum_ovf
  );
endinterface

// File: rtl/crossbar_accumulator_sat_add_u.sv
// Combinational unsigned saturating adder: sum_o = min(a_i + b_i, 2^ACC_W-1).
module sat_add_u #(
  parameter int unsigned ACC_W  = crossbar_pkg::ACC_W,
  parameter int unsigned PROD_W = crossbar_pkg::PROD_W
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);
  import crossbar_pkg::*;

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a_i} + (ACC_W + 1)'(b_i);
    ovf_o = full[ACC_W];
    sum_o = ovf_o ? ACC_W'(sat_max(ACC_W)) : full[ACC_W-1:0];
  end

endmodule

// File: rtl/crossbar_accumulator.sv
// Sums VEC_LEN consecutive unsigned products into a saturated dot product and hands the
// result downstream over a valid/ready handshake together with a sticky overflow flag.
module crossbar_accumulator #(
  parameter int unsigned PROD_W  = crossbar_pkg::PROD_W,
  parameter int unsigned ACC_W   = crossbar_pkg::ACC_W,
  parameter int unsigned VEC_LEN = 4
) (
  input logic                   clock,
  input logic                   reset_n,
  input logic                   acc_clear,
  crossbar_accumulator_if.slave bus
);
  import crossbar_pkg::*;

  localparam int unsigned CNT_W = $clog2(VEC_LEN) + 1;

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sum_valid_q, sum_valid_d;
  logic [ACC_W-1:0] sum_data_q, sum_data_d;
  logic             sum_ovf_q, sum_ovf_d;

  logic             prod_ready;
  logic             accept;
  logic             handshake;
  logic             last;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_add_u #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (bus.prod_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // In HOLD a new product may only enter when the pending result leaves in the same cycle.
  assign prod_ready = reset_n & ((state_q == ACCUM) | bus.sum_ready);
  assign accept     = bus.prod_valid & prod_ready;
  assign handshake  = sum_valid_q & bus.sum_ready;
  assign last       = (cnt_q == CNT_W'(VEC_LEN - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_valid_d = sum_valid_q;
    sum_data_d  = sum_data_q;
    sum_ovf_d   = sum_ovf_q;

    if (acc_clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      sum_valid_d = 1'b0;
    end else if (accept) begin
      // acc/cnt/ovf are already zero in HOLD, so an accept there starts a fresh vector.
      if (last) begin
        state_d     = HOLD;
        sum_valid_d = 1'b1;
        sum_data_d  = add_sum;
        sum_ovf_d   = ovf_q | add_ovf;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        state_d     = ACCUM;
        sum_valid_d = 1'b0;
        acc_d       = add_sum;
        cnt_d       = cnt_q + CNT_W'(1);
        ovf_d       = ovf_q | add_ovf;
      end
    end else if ((state_q == HOLD) && handshake) begin
      state_d     = ACCUM;
      sum_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_ovf_q   <= sum_ovf_d;
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.sum_data   = sum_data_q;
  assign bus.sum_ovf    = sum_ovf_q;

endmodule

// File: tb/tb_crossbar_accumulator.sv
// Drives a 12-bit and a 9-bit accumulator with identical stimulus and compares both against
// a vector-level reference: result = min(sum of products, max), ovf = (sum > max).
module tb_crossbar_accumulator;
  localparam int unsigned VL = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       acc_clear = 1'b0;
  logic       prod_valid = 1'b0;
  logic       sum_ready = 1'b0;
  logic [7:0] prod_data = 8'd0;

  always #5 clock = ~clock;

  crossbar_accumulator_if #(.PROD_W(8), .ACC_W(12)) if12 ();
  crossbar_accumulator_if #(.PROD_W(8), .ACC_W(9))  if9 ();

  assign if12.prod_valid = prod_valid;
  assign if12.prod_data  = prod_data;
  assign if12.sum_ready  = sum_ready;
  assign if9.prod_valid  = prod_valid;
  assign if9.prod_data   = prod_data;
  assign if9.sum_ready   = sum_ready;

  crossbar_accumulator #(.PROD_W(8), .ACC_W(12), .VEC_LEN(VL)) dut12 (
    .clock     (clock),
    .reset_n   (reset_n),
    .acc_clear (acc_clear),
    .bus       (if12)
  );

  crossbar_accumulator #(.PROD_W(8), .ACC_W(9), .VEC_LEN(VL)) dut9 (
    .clock     (clock),
    .reset_n   (reset_n),
    .acc_clear (acc_clear),
    .bus       (if9)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: products collected per vector, one pending result at most.
  int vec[$];
  bit pending;
  int e12, e9, n_hs;
  bit o12, o9;

  function automatic void sat_sum(input int q[$], input int w, output int s, output bit o);
    int mx;
    mx = (1 << w) - 1;
    s  = 0;
    foreach (q[i]) s += q[i];
    o = (s > mx);
    if (o) s = mx;
  endfunction

  task automatic model_reset();
    vec.delete();
    pending = 1'b0;
    e12 = 0; o12 = 1'b0;
    e9  = 0; o9  = 1'b0;
  endtask

  // Applies the coming posedge to the reference, then waits until the next negedge.
  task automatic step();
    bit acc;
    if (acc_clear) begin
      vec.delete();
      pending = 1'b0;
    end else begin
      acc = prod_valid && (!pending || sum_ready);
      if (pending && sum_ready) begin
        pending = 1'b0;
        n_hs++;
      end
      if (acc) begin
        vec.push_back(int'(prod_data));
        if (vec.size() == VL) begin
          sat_sum(vec, 12, e12, o12);
          sat_sum(vec, 9, e9, o9);
          pending = 1'b1;
          vec.delete();
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit v, input int d, input bit sr, input bit clr);
    prod_valid = v;
    prod_data  = 8'(d);
    sum_ready  = sr;
    acc_clear  = clr;
  endtask

  task automatic test_reset();
    int seq[4] = '{1, 2, 3, 4};
    model_reset();
    @(negedge clock);
    n_checks += 2;
    if ({if12.sum_valid, if12.sum_ovf, if12.sum_data, if12.prod_ready} !== '0) begin
      n_fail++; $display("FAIL reset12 got %b want 0", {if12.sum_valid, if12.sum_ovf,
                         if12.sum_data, if12.prod_ready});
    end
    if ({if9.sum_valid, if9.sum_ovf, if9.sum_data, if9.prod_ready} !== '0) begin
      n_fail++; $display("FAIL reset9 got %b want 0", {if9.sum_valid, if9.sum_ovf,
                         if9.sum_data, if9.prod_ready});
    end
    reset_n = 1'b1;
    drive(1, 3, 1, 0); step();
    drive(1, 5, 1, 0); step();
    #2 reset_n = 1'b0;
    #1;
    n_checks += 2;
    if ({if12.sum_valid, if12.sum_data, if12.prod_ready} !== '0) begin
      n_fail++; $display("FAIL reset_mid12 got v=%b d=%0d r=%b want 0", if12.sum_valid,
                         if12.sum_data, if12.prod_ready);
    end
    if ({if9.sum_valid, if9.sum_data, if9.prod_ready} !== '0) begin
      n_fail++; $display("FAIL reset_mid9 got v=%b d=%0d r=%b want 0", if9.sum_valid,
                         if9.sum_data, if9.prod_ready);
    end
    drive(0, 0, 1, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    foreach (seq[i]) begin
      drive(1, seq[i], 1, 0); step();
    end
    n_checks++;
    if (!(if12.sum_valid === 1'b1 && if12.sum_data === 12'd10 && if9.sum_data === 9'd10)) begin
      n_fail++; $display("FAIL reset_after got v=%b d12=%0d d9=%0d want v=1 d=10",
                         if12.sum_valid, if12.sum_data, if9.sum_data);
    end
    drive(0, 0, 1, 0); step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      drive(1, 225, 1, 0); step();
      n_checks++;
      if (if12.sum_valid !== (i == 3)) begin
        n_fail++; $display("FAIL basic_valid[%0d] got %b want %b", i, if12.sum_valid, i == 3);
      end
    end
    n_checks += 2;
    if (if12.sum_data !== 12'd900 || if12.sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic12 got %0d/%b want 900/0", if12.sum_data, if12.sum_ovf);
    end
    if (if9.sum_data !== 9'd511 || if9.sum_ovf !== 1'b1) begin
      n_fail++; $display("FAIL basic9 got %0d/%b want 511/1", if9.sum_data, if9.sum_ovf);
    end
    drive(0, 0, 1, 0); step();
    n_checks++;
    if (if12.sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse got %b want 0", if12.sum_valid);
    end
  endtask

  task automatic test_back_pressure();
    int seq[4] = '{10, 20, 30, 40};
    int nxt[3] = '{8, 9, 10};
    foreach (seq[i]) begin
      drive(1, seq[i], 0, 0); step();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1, 77, 0, 0);
      #1;
      n_checks++;
      if (if12.prod_ready !== 1'b0 || if9.prod_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready[%0d] got %b%b want 00", c, if12.prod_ready,
                           if9.prod_ready);
      end
      step();
      n_checks++;
      if (if12.sum_valid !== 1'b1 || if12.sum_data !== 12'd100 || if9.sum_data !== 9'd100) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%b d=%0d want v=1 d=100", c,
                           if12.sum_valid, if12.sum_data);
      end
    end
    drive(1, 7, 1, 0);
    #1;
    n_checks++;
    if (if12.prod_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready got %b want 1", if12.prod_ready);
    end
    step();
    n_checks++;
    if (if12.sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release_valid got %b want 0", if12.sum_valid);
    end
    foreach (nxt[i]) begin
      drive(1, nxt[i], 1, 0); step();
    end
    n_checks++;
    if (if12.sum_valid !== 1'b1 || if12.sum_data !== 12'd34) begin
      n_fail++; $display("FAIL bp_next got v=%b d=%0d want v=1 d=34", if12.sum_valid,
                         if12.sum_data);
    end
    drive(0, 0, 1, 0); step();
  endtask

  task automatic test_saturation();
    int sat[4] = '{200, 200, 150, 1};
    foreach (sat[i]) begin
      drive(1, sat[i], 1, 0); step();
    end
    n_checks += 2;
    if (if9.sum_data !== 9'd511 || if9.sum_ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat9 got %0d/%b want 511/1", if9.sum_data, if9.sum_ovf);
    end
    if (if12.sum_data !== 12'd551 || if12.sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat12 got %0d/%b want 551/0", if12.sum_data, if12.sum_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0); step();
    end
    n_checks++;
    if (if9.sum_valid !== 1'b1 || if9.sum_data !== 9'd4 || if9.sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL sat_after got v=%b %0d/%b want 1 4/0", if9.sum_valid,
                         if9.sum_data, if9.sum_ovf);
    end
    drive(0, 0, 1, 0); step();
  endtask

  task automatic test_clear();
    int seq[4] = '{1, 2, 3, 4};
    int hs_before;
    for (int i = 0; i < 3; i++) begin
      drive(1, 50, 1, 0); step();
    end
    drive(1, 99, 1, 1); step();
    foreach (seq[i]) begin
      drive(1, seq[i], 0, 0); step();
    end
    n_checks++;
    if (if12.sum_valid !== 1'b1 || if12.sum_data !== 12'd10 || if9.sum_data !== 9'd10) begin
      n_fail++; $display("FAIL clear_drop got v=%b d=%0d want v=1 d=10", if12.sum_valid,
                         if12.sum_data);
    end
    hs_before = n_hs;
    drive(0, 0, 1, 1); step();
    n_checks++;
    if (if12.sum_valid !== 1'b0 || if9.sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_hold got %b%b want 00", if12.sum_valid, if9.sum_valid);
    end
    drive(0, 0, 1, 0); step();
    n_checks++;
    if (if12.sum_valid !== 1'b0 || n_hs != hs_before) begin
      n_fail++; $display("FAIL clear_no_hs got v=%b hs=%0d want v=0 hs=%0d", if12.sum_valid,
                         n_hs, hs_before);
    end
  endtask

  task automatic test_random_stress();
    int start_hs;
    int cycles;
    start_hs = n_hs;
    cycles   = 0;
    while ((n_hs - start_hs) < 1000 && cycles < 40000 && n_fail < 50) begin
      drive(($urandom % 4) != 0, int'($urandom_range(0, 255)), $urandom % 2,
            ($urandom % 300) == 0);
      #1;
      n_checks++;
      if (if12.prod_ready !== (!pending || sum_ready) || if9.prod_ready !== if12.prod_ready) begin
        n_fail++; $display("FAIL stress_ready cyc=%0d got %b%b want %b", cycles,
                           if12.prod_ready, if9.prod_ready, !pending || sum_ready);
      end
      step();
      cycles++;
      n_checks++;
      if (if12.sum_valid !== pending || if9.sum_valid !== pending) begin
        n_fail++; $display("FAIL stress_valid cyc=%0d got %b%b want %b", cycles,
                           if12.sum_valid, if9.sum_valid, pending);
      end else if (pending) begin
        n_checks++;
        if (if12.sum_data !== 12'(e12) || if12.sum_ovf !== o12 ||
            if9.sum_data !== 9'(e9) || if9.sum_ovf !== o9) begin
          n_fail++; $display("FAIL stress_data cyc=%0d got %0d/%b %0d/%b want %0d/%b %0d/%b",
                             cycles, if12.sum_data, if12.sum_ovf, if9.sum_data, if9.sum_ovf,
                             e12, o12, e9, o9);
        end
      end
    end
    n_checks++;
    if ((n_hs - start_hs) < 1000) begin
      n_fail++; $display("FAIL stress_budget got %0d results want 1000", n_hs - start_hs);
    end
  endtask

  initial begin
    n_hs = 0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_saturation();
    test_clear();
    test_random_stress();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
